// File: rtl/xgemac_tx_frame_stager_pkg.sv
// Shared types for the XGE MAC transmit frame stager: read FSM states and the
// layout of one buffered frame word.
package xgemac_rtl_pkg;

  localparam int XGE_WORD_W = 64;
  localparam int XGE_MOD_W  = 3;
  localparam int STG_WORD_W = 1 + XGE_MOD_W + XGE_WORD_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } stg_state_t;

  typedef struct packed {
    logic                  eop;
    logic [XGE_MOD_W-1:0]  mod;
    logic [XGE_WORD_W-1:0] data;
  } stg_word_t;

endpackage

// File: rtl/xgemac_tx_frame_stager_sdp_ram.sv
// Simple dual-port RAM: one write port and one registered read port on a single clock.
// The read data holds its value when no read is issued.
module xgemac_sdp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 68,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xgemac_tx_frame_stager.sv
// Store-and-forward frame buffer in front of the XGE MAC pkt_tx interface: a frame is
// replayed only once its EOP word is buffered, so the MAC never sees a mid-frame underrun.
module xgemac_tx_frame_stager
  import xgemac_rtl_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DROP_W = 16
) (
  input  logic                    clk_156m25,
  input  logic                    rst_156m25,
  input  logic [XGE_WORD_W-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [XGE_MOD_W-1:0]    in_mod,
  output logic [XGE_WORD_W-1:0]   pkt_tx_data,
  output logic                    pkt_tx_val,
  output logic                    pkt_tx_sop,
  output logic                    pkt_tx_eop,
  output logic [XGE_MOD_W-1:0]    pkt_tx_mod,
  input  logic                    pkt_tx_full,
  output logic [$clog2(DEPTH):0]  frames_pending,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one extra wrap bit: equal index with differing MSB means full.
  function automatic logic ptr_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[PW-1] != r[PW-1]) && (w[PW-2:0] == r[PW-2:0]);
  endfunction

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         wr_start_q, wr_start_d;
  logic                  open_q, open_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         pend_q, pend_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  stg_state_t            state_q, state_d;
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_sop_q, rd_sop_d;
  logic [XGE_WORD_W-1:0] tx_data_q, tx_data_d;
  logic                  tx_val_q, tx_val_d;
  logic                  tx_sop_q, tx_sop_d;
  logic                  tx_eop_q, tx_eop_d;
  logic [XGE_MOD_W-1:0]  tx_mod_q, tx_mod_d;

  logic [PW-1:0]         wr_addr_s;
  logic                  we_s;
  logic                  commit_s;
  logic                  drop_s;
  logic                  rd_en_s;
  logic                  eop_seen_s;
  stg_word_t             wr_word_s;
  stg_word_t             rd_word_s;
  logic [STG_WORD_W-1:0] wr_raw_s;
  logic [STG_WORD_W-1:0] rd_raw_s;

  assign wr_word_s = '{eop: in_eop, mod: in_mod, data: in_data};
  assign wr_raw_s  = wr_word_s;
  assign rd_word_s = rd_raw_s;

  xgemac_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (STG_WORD_W)
  ) u_ram (
    .clk   (clk_156m25),
    .we    (we_s),
    .waddr (wr_addr_s[AW-1:0]),
    .wdata (wr_raw_s),
    .re    (rd_en_s),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_raw_s)
  );

  // Write side: an SOP always restarts at wr_start, which also rewinds any open frame.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    wr_start_d = wr_start_q;
    open_d     = open_q;
    wr_addr_s  = wr_ptr_q;
    we_s       = 1'b0;
    commit_s   = 1'b0;
    drop_s     = 1'b0;
    if (in_valid && (in_sop || open_q)) begin
      wr_addr_s = in_sop ? wr_start_q : wr_ptr_q;
      if (ptr_full(wr_addr_s, rd_ptr_q)) begin
        wr_ptr_d = wr_start_q;
        open_d   = 1'b0;
        drop_s   = 1'b1;
      end else begin
        we_s     = 1'b1;
        wr_ptr_d = wr_addr_s + PW'(1'b1);
        drop_s   = in_sop && open_q;
        open_d   = !in_eop;
        commit_s = in_eop;
        if (in_eop) begin
          wr_start_d = wr_addr_s + PW'(1'b1);
        end else begin
          wr_start_d = wr_start_q;
        end
      end
    end else begin
      wr_addr_s = wr_ptr_q;
    end
  end

  // Read side: the EOP flag is seen one cycle after its read, which also forces the idle gap.
  always_comb begin
    eop_seen_s = rd_vld_q && rd_word_s.eop;
    state_d    = state_q;
    rd_en_s    = 1'b0;
    rd_sop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if ((pend_q != {PW{1'b0}}) && !pkt_tx_full) begin
          rd_en_s  = 1'b1;
          rd_sop_d = 1'b1;
          state_d  = SEND;
        end else begin
          state_d  = IDLE;
        end
      end
      SEND: begin
        if (eop_seen_s) begin
          state_d = IDLE;
        end else begin
          rd_en_s = !pkt_tx_full;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_vld_d = rd_en_s;
    rd_ptr_d = rd_en_s ? (rd_ptr_q + PW'(1'b1)) : rd_ptr_q;
  end

  // Frame and drop accounting.
  always_comb begin
    case ({commit_s, eop_seen_s})
      2'b10:   pend_d = pend_q + PW'(1'b1);
      2'b01:   pend_d = pend_q - PW'(1'b1);
      default: pend_d = pend_q;
    endcase
    if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1'b1);
    end else begin
      drop_d = drop_q;
    end
  end

  always_comb begin
    tx_val_d  = rd_vld_q;
    tx_sop_d  = rd_vld_q && rd_sop_q;
    tx_eop_d  = eop_seen_s;
    tx_mod_d  = eop_seen_s ? rd_word_s.mod : {XGE_MOD_W{1'b0}};
    tx_data_d = rd_vld_q ? rd_word_s.data : {XGE_WORD_W{1'b0}};
  end

  always_ff @(posedge clk_156m25) begin
    if (rst_156m25) begin
      wr_ptr_q   <= {PW{1'b0}};
      wr_start_q <= {PW{1'b0}};
      open_q     <= 1'b0;
      rd_ptr_q   <= {PW{1'b0}};
      pend_q     <= {PW{1'b0}};
      drop_q     <= {DROP_W{1'b0}};
      state_q    <= IDLE;
      rd_vld_q   <= 1'b0;
      rd_sop_q   <= 1'b0;
      tx_data_q  <= {XGE_WORD_W{1'b0}};
      tx_val_q   <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_mod_q   <= {XGE_MOD_W{1'b0}};
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_start_q <= wr_start_d;
      open_q     <= open_d;
      rd_ptr_q   <= rd_ptr_d;
      pend_q     <= pend_d;
      drop_q     <= drop_d;
      state_q    <= state_d;
      rd_vld_q   <= rd_vld_d;
      rd_sop_q   <= rd_sop_d;
      tx_data_q  <= tx_data_d;
      tx_val_q   <= tx_val_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_mod_q   <= tx_mod_d;
    end
  end

  assign pkt_tx_data    = tx_data_q;
  assign pkt_tx_val     = tx_val_q;
  assign pkt_tx_sop     = tx_sop_q;
  assign pkt_tx_eop     = tx_eop_q;
  assign pkt_tx_mod     = tx_mod_q;
  assign frames_pending = pend_q;
  assign drop_cnt       = drop_q;

endmodule

// File: tb/tb_xgemac_tx_frame_stager.sv
// Directed bench for xgemac_tx_frame_stager: captures every pkt_tx word with its cycle
// number and compares against hand-computed frames, gaps, counts and latencies.
module tb_xgemac_tx_frame_stager;

  localparam int DEPTH  = 256;
  localparam int DROP_W = 16;

  logic        clk_156m25 = 1'b0;
  logic        rst_156m25 = 1'b1;
  logic [63:0] in_data    = 64'd0;
  logic        in_valid   = 1'b0;
  logic        in_sop     = 1'b0;
  logic        in_eop     = 1'b0;
  logic [2:0]  in_mod     = 3'd0;
  logic [63:0] pkt_tx_data;
  logic        pkt_tx_val;
  logic        pkt_tx_sop;
  logic        pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic        pkt_tx_full = 1'b0;
  logic [8:0]  frames_pending;
  logic [15:0] drop_cnt;

  xgemac_tx_frame_stager #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_156m25     (clk_156m25),
    .rst_156m25     (rst_156m25),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_sop         (in_sop),
    .in_eop         (in_eop),
    .in_mod         (in_mod),
    .pkt_tx_data    (pkt_tx_data),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_full    (pkt_tx_full),
    .frames_pending (frames_pending),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk_156m25 = ~clk_156m25;

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic        e;
    logic [2:0]  m;
    int          cyc;
  } mon_t;

  mon_t mon_q[$];
  int   cyc      = 0;
  int   passed   = 0;
  int   failed   = 0;
  int   total    = 0;
  int   pend_max = 0;
  int   eop_edge = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge and log any issued word.
  task automatic tick();
    @(posedge clk_156m25);
    #1;
    cyc++;
    if (pkt_tx_val) mon_q.push_back('{pkt_tx_data, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, cyc});
    if (int'(frames_pending) > pend_max) pend_max = int'(frames_pending);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_mod = 3'd0; in_data = 64'd0;
  endtask

  task automatic send_frame(input int n, input logic [2:0] m, input logic [63:0] base,
                            output int edge_n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_sop   = (i == 0);
      in_eop   = (i == n - 1);
      in_mod   = (i == n - 1) ? m : 3'd0;
      in_data  = base + 64'(i);
      tick();
    end
    idle_inputs();
    edge_n = cyc;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int k = 0; k < budget && mon_q.size() < n; k++) tick();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic check_frame(input string tag, input int n, input logic [2:0] m,
                             input logic [63:0] base);
    check({tag, "_count"}, 64'(mon_q.size()), 64'(n));
    for (int i = 0; i < n && i < mon_q.size(); i++) begin
      check({tag, "_data"}, mon_q[i].d, base + 64'(i));
      check({tag, "_sop"},  64'(mon_q[i].s), 64'(i == 0));
      check({tag, "_eop"},  64'(mon_q[i].e), 64'(i == n - 1));
      check({tag, "_mod"},  64'(mon_q[i].m), (i == n - 1) ? 64'(m) : 64'd0);
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_val",  64'(pkt_tx_val), 64'd0);
    check("rst_sop",  64'(pkt_tx_sop), 64'd0);
    check("rst_eop",  64'(pkt_tx_eop), 64'd0);
    check("rst_mod",  64'(pkt_tx_mod), 64'd0);
    check("rst_data", pkt_tx_data, 64'd0);
    check("rst_pend", 64'(frames_pending), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst_156m25 = 1'b0;
    repeat (2) tick();

    // 1: single 8-word frame, mod=3, first word two edges after the EOP write
    mon_q.delete();
    send_frame(8, 3'd3, 64'h1111_0000_0000_0000, eop_edge);
    check("t1_pend_after_eop", 64'(frames_pending), 64'd1);
    wait_words(8, 40);
    check_frame("t1", 8, 3'd3, 64'h1111_0000_0000_0000);
    if (mon_q.size() > 0) check("t1_latency", 64'(mon_q[0].cyc), 64'(eop_edge + 2));
    check("t1_pend_done", 64'(frames_pending), 64'd0);

    // 2: pkt_tx_full high for 5 cycles mid-frame
    mon_q.delete();
    send_frame(8, 3'd5, 64'h2222_0000_0000_0000, eop_edge);
    repeat (3) tick();
    pkt_tx_full = 1'b1;
    repeat (5) tick();
    pkt_tx_full = 1'b0;
    wait_words(8, 40);
    check_frame("t2", 8, 3'd5, 64'h2222_0000_0000_0000);
    if (mon_q.size() == 8) begin
      check("t2_latency", 64'(mon_q[0].cyc), 64'(eop_edge + 2));
      check("t2_gap",     64'(mon_q[3].cyc - mon_q[2].cyc), 64'd6);
      check("t2_span",    64'(mon_q[7].cyc - mon_q[0].cyc), 64'd12);
    end

    // 3: oversize frame of DEPTH+1 words is dropped, a following frame goes through
    mon_q.delete();
    send_frame(DEPTH + 1, 3'd1, 64'h3333_0000_0000_0000, eop_edge);
    repeat (20) tick();
    check("t3_drop",    64'(drop_cnt), 64'd1);
    check("t3_no_out",  64'(mon_q.size()), 64'd0);
    check("t3_pend",    64'(frames_pending), 64'd0);
    send_frame(4, 3'd0, 64'h3434_0000_0000_0000, eop_edge);
    wait_words(4, 40);
    check_frame("t3b", 4, 3'd0, 64'h3434_0000_0000_0000);

    // 4: SOP on word 3 of an open frame aborts it
    mon_q.delete();
    pend_max = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_sop = (i == 0); in_eop = 1'b0; in_mod = 3'd0;
      in_data  = 64'hAAAA_0000_0000_0000 + 64'(i);
      tick();
    end
    send_frame(5, 3'd5, 64'h4444_0000_0000_0000, eop_edge);
    wait_words(5, 40);
    check("t4_drop", 64'(drop_cnt), 64'd2);
    check_frame("t4", 5, 3'd5, 64'h4444_0000_0000_0000);
    check("t4_pend_peak", 64'(pend_max), 64'd1);

    // 5: 1-word frames every other cycle; each commit coincides with the previous EOP read
    mon_q.delete();
    for (int f = 0; f < 4; f++) begin
      in_valid = 1'b1; in_sop = 1'b1; in_eop = 1'b1; in_mod = 3'(f + 1);
      in_data  = 64'h5555_0000_0000_0000 + 64'(f);
      tick();
      if (f == 0) eop_edge = cyc;
      check("t5_pend_w", 64'(frames_pending), 64'd1);
      idle_inputs();
      tick();
      check("t5_pend_i", 64'(frames_pending), 64'd1);
    end
    wait_words(4, 20);
    check("t5_count", 64'(mon_q.size()), 64'd4);
    for (int f = 0; f < 4 && f < mon_q.size(); f++) begin
      check("t5_data",  mon_q[f].d, 64'h5555_0000_0000_0000 + 64'(f));
      check("t5_sopeop", {62'd0, mon_q[f].s, mon_q[f].e}, 64'd3);
      check("t5_mod",   64'(mon_q[f].m), 64'(f + 1));
      check("t5_cycle", 64'(mon_q[f].cyc), 64'(eop_edge + 2 + 2 * f));
    end
    check("t5_pend_done", 64'(frames_pending), 64'd0);

    // 6: synchronous reset while a frame is being sent
    mon_q.delete();
    send_frame(8, 3'd2, 64'h6666_0000_0000_0000, eop_edge);
    repeat (3) tick();
    rst_156m25 = 1'b1;
    tick();
    check("t6_val",  64'(pkt_tx_val), 64'd0);
    check("t6_pend", 64'(frames_pending), 64'd0);
    check("t6_drop", 64'(drop_cnt), 64'd0);
    rst_156m25 = 1'b0;
    tick();
    mon_q.delete();
    send_frame(3, 3'd6, 64'h7777_0000_0000_0000, eop_edge);
    wait_words(3, 40);
    check_frame("t6b", 3, 3'd6, 64'h7777_0000_0000_0000);
    if (mon_q.size() > 0) check("t6b_latency", 64'(mon_q[0].cyc), 64'(eop_edge + 2));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
